// File: rtl/capture_ctrl.sv
// capture_ctrl: streams probe samples into a 1K-word BRAM used as a circular
// buffer, freezes 1024 samples around a trigger with a programmable pre-trigger
// depth, then replays them oldest-first over a valid/ready handshake.
module capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_arm,
  input  logic              in_abort,
  input  logic [ADDR_W-1:0] in_pretrig,
  input  logic              in_sample_en,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              in_trig,
  input  logic              in_rd_start,
  input  logic              in_rd_ready,
  input  logic [DATA_W-1:0] in_ram_data,
  output logic              out_ram_we,
  output logic [ADDR_W-1:0] out_ram_addr,
  output logic [DATA_W-1:0] out_ram_data,
  output logic              out_rd_valid,
  output logic [DATA_W-1:0] out_rd_data,
  output logic [ADDR_W-1:0] out_start_addr,
  output logic              out_busy,
  output logic              out_armed,
  output logic              out_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WAIT_TRIG, S_POST, S_DONE, S_RD_ADDR, S_RD_CAP, S_RD_HOLD
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] pretrig;   // latched pre-trigger depth P
  logic [ADDR_W-1:0] wr_ptr;    // next circular write address
  logic [ADDR_W-1:0] remain;    // writes left in FILL, or post-trigger writes left in POST
  logic [ADDR_W-1:0] rd_idx;    // readout word index, 0 = oldest

  // Status flags {busy, armed, done} that belong to a state; loaded together
  // with the state so the flags are registered and change on the same edge.
  function automatic logic [2:0] status_of(input state_t s);
    status_of = {(s == S_FILL) || (s == S_WAIT_TRIG) || (s == S_POST),
                 (s == S_WAIT_TRIG),
                 (s == S_DONE)};
  endfunction

  // Sequencer: capture writes, trigger handling and the 3-cycle readout loop.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state          <= S_IDLE;
      pretrig        <= '0;
      wr_ptr         <= '0;
      remain         <= '0;
      rd_idx         <= '0;
      out_ram_we     <= 1'b0;
      out_ram_addr   <= '0;
      out_ram_data   <= '0;
      out_rd_valid   <= 1'b0;
      out_rd_data    <= '0;
      out_start_addr <= '0;
      out_busy       <= 1'b0;
      out_armed      <= 1'b0;
      out_done       <= 1'b0;
    end else begin
      out_ram_we <= 1'b0;
      if (in_abort) begin
        state        <= S_IDLE;
        out_rd_valid <= 1'b0;
        {out_busy, out_armed, out_done} <= status_of(S_IDLE);
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (in_arm) begin
              pretrig <= in_pretrig;
              wr_ptr  <= '0;
              remain  <= in_pretrig;
              if (in_pretrig == '0) begin
                state <= S_WAIT_TRIG;
                {out_busy, out_armed, out_done} <= status_of(S_WAIT_TRIG);
              end else begin
                state <= S_FILL;
                {out_busy, out_armed, out_done} <= status_of(S_FILL);
              end
            end else if ((state == S_DONE) && in_rd_start) begin
              rd_idx       <= '0;
              out_ram_addr <= out_start_addr;
              state        <= S_RD_ADDR;
              {out_busy, out_armed, out_done} <= status_of(S_RD_ADDR);
            end
          end
          S_FILL: begin
            if (in_sample_en) begin
              out_ram_we   <= 1'b1;
              out_ram_addr <= wr_ptr;
              out_ram_data <= in_sample;
              wr_ptr       <= wr_ptr + ADDR_ONE;
              remain       <= remain - ADDR_ONE;
              if (remain == ADDR_ONE) begin
                state <= S_WAIT_TRIG;
                {out_busy, out_armed, out_done} <= status_of(S_WAIT_TRIG);
              end
            end
          end
          S_WAIT_TRIG: begin
            if (in_sample_en) begin
              out_ram_we   <= 1'b1;
              out_ram_addr <= wr_ptr;
              out_ram_data <= in_sample;
              wr_ptr       <= wr_ptr + ADDR_ONE;
              if (in_trig) begin
                // oldest kept sample sits P words before the trigger, modulo depth
                out_start_addr <= wr_ptr - pretrig;
                remain         <= ADDR_LAST - pretrig;
                if (pretrig == ADDR_LAST) begin
                  state <= S_DONE;
                  {out_busy, out_armed, out_done} <= status_of(S_DONE);
                end else begin
                  state <= S_POST;
                  {out_busy, out_armed, out_done} <= status_of(S_POST);
                end
              end
            end
          end
          S_POST: begin
            if (in_sample_en) begin
              out_ram_we   <= 1'b1;
              out_ram_addr <= wr_ptr;
              out_ram_data <= in_sample;
              wr_ptr       <= wr_ptr + ADDR_ONE;
              remain       <= remain - ADDR_ONE;
              if (remain == ADDR_ONE) begin
                state <= S_DONE;
                {out_busy, out_armed, out_done} <= status_of(S_DONE);
              end
            end
          end
          S_RD_ADDR: begin
            // address is on the BRAM this cycle; data returns next cycle
            state <= S_RD_CAP;
          end
          S_RD_CAP: begin
            out_rd_data  <= in_ram_data;
            out_rd_valid <= 1'b1;
            state        <= S_RD_HOLD;
          end
          S_RD_HOLD: begin
            if (in_rd_ready) begin
              out_rd_valid <= 1'b0;
              rd_idx       <= rd_idx + ADDR_ONE;
              if (rd_idx == ADDR_LAST) begin
                state <= S_DONE;
                {out_busy, out_armed, out_done} <= status_of(S_DONE);
              end else begin
                out_ram_addr <= out_start_addr + rd_idx + ADDR_ONE;
                state        <= S_RD_ADDR;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            {out_busy, out_armed, out_done} <= status_of(S_IDLE);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: BRAM model, write/read scoreboards, a table of
// capture scenarios and hand-written reset/stall/abort sequences.
module tb_capture_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;

  logic              in_clk = 1'b0;
  logic              in_rst = 1'b1;
  logic              in_arm = 1'b0;
  logic              in_abort = 1'b0;
  logic [ADDR_W-1:0] in_pretrig = '0;
  logic              in_sample_en = 1'b0;
  logic [DATA_W-1:0] in_sample = '0;
  logic              in_trig = 1'b0;
  logic              in_rd_start = 1'b0;
  logic              in_rd_ready = 1'b0;
  logic [DATA_W-1:0] in_ram_data = '0;
  logic              out_ram_we;
  logic [ADDR_W-1:0] out_ram_addr;
  logic [DATA_W-1:0] out_ram_data;
  logic              out_rd_valid;
  logic [DATA_W-1:0] out_rd_data;
  logic [ADDR_W-1:0] out_start_addr;
  logic              out_busy;
  logic              out_armed;
  logic              out_done;

  capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_arm(in_arm), .in_abort(in_abort),
    .in_pretrig(in_pretrig), .in_sample_en(in_sample_en), .in_sample(in_sample),
    .in_trig(in_trig), .in_rd_start(in_rd_start), .in_rd_ready(in_rd_ready),
    .in_ram_data(in_ram_data), .out_ram_we(out_ram_we), .out_ram_addr(out_ram_addr),
    .out_ram_data(out_ram_data), .out_rd_valid(out_rd_valid), .out_rd_data(out_rd_data),
    .out_start_addr(out_start_addr), .out_busy(out_busy), .out_armed(out_armed),
    .out_done(out_done)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    int addr;
    int data;
    bit last;
  } wr_t;

  typedef struct {
    int p;
    int trig_k;
    int base;
    bit gaps;
    int exp_start;
    int w0;
    int w4;
    int w_last;
  } cap_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   stray = 0;
  bit   rd_mon = 1'b0;
  int   recv_n = 0;
  int   got [DEPTH];
  int   shadow [DEPTH];
  wr_t  wq [$];
  int   rdq [$];
  cap_t tbl [4];
  logic [DATA_W-1:0] mem [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // BRAM model: one-cycle synchronous read, write on we.
  always @(posedge in_clk) begin
    if (out_ram_we) mem[out_ram_addr] <= out_ram_data;
    in_ram_data <= mem[out_ram_addr];
  end

  // Monitor: every BRAM write and every accepted readout word is scored.
  always @(negedge in_clk) begin
    wr_t e;
    int  x;
    if (!in_rst) begin
      if (out_ram_we) begin
        if (wq.size() == 0) begin
          stray++;
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing pending", out_ram_addr, out_ram_data);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 64'(out_ram_addr), 64'(e.addr));
          chk("wr_data", 64'(out_ram_data), 64'(e.data));
          chk("done_with_last_write", 64'(out_done), 64'(e.last));
          chk("busy_during_write", 64'(out_busy), 64'(!e.last));
        end
      end
      if (rd_mon && out_rd_valid && in_rd_ready) begin
        if (rdq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_rd_word: got 0x%0h with nothing expected", out_rd_data);
        end else begin
          x = rdq.pop_front();
          chk("rd_word", 64'(out_rd_data), 64'(x));
          if (recv_n < DEPTH) got[recv_n] = int'(out_rd_data);
          recv_n++;
        end
      end
    end
  end

  // Drive one capture; stop_after >= 0 drives only that many samples.
  task automatic capture(input cap_t c, input int stop_after);
    int n_total, limit, k, cyc, d;
    wr_t w;
    n_total = c.trig_k + 1 + (DEPTH - 1) - c.p;
    limit = (stop_after >= 0) ? stop_after : n_total;
    @(posedge in_clk); #1;
    in_arm = 1'b1;
    in_pretrig = ADDR_W'(c.p);
    @(posedge in_clk); #1;
    in_arm = 1'b0;
    k = 0;
    cyc = 0;
    while (k < limit) begin
      if (c.gaps && (cyc % 7 == 3)) begin
        in_sample_en = 1'b0;
        in_trig = 1'b1;
      end else begin
        d = (c.base + k) & 16'hFFFF;
        in_sample_en = 1'b1;
        in_sample = DATA_W'(d);
        in_trig = (k == c.trig_k) || (c.gaps && (k < c.p));
        shadow[k % DEPTH] = d;
        w.addr = k % DEPTH;
        w.data = d;
        w.last = (k == n_total - 1);
        wq.push_back(w);
        k++;
      end
      cyc++;
      @(posedge in_clk); #1;
    end
    in_sample_en = 1'b0;
    in_trig = 1'b0;
  endtask

  // Full readout under random back-pressure; returns in DONE.
  task automatic readout(input string tag, input cap_t c);
    int cycles;
    recv_n = 0;
    for (int i = 0; i < DEPTH; i++) rdq.push_back(shadow[(c.exp_start + i) % DEPTH]);
    rd_mon = 1'b1;
    @(posedge in_clk); #1;
    in_rd_start = 1'b1;
    @(posedge in_clk); #1;
    in_rd_start = 1'b0;
    cycles = 0;
    while (!(out_done && rdq.size() == 0) && cycles < 20000) begin
      in_rd_ready = 1'($urandom_range(0, 1));
      @(posedge in_clk); #1;
      cycles++;
    end
    in_rd_ready = 1'b0;
    rd_mon = 1'b0;
    chk({tag, "_rd_within_bound"}, 64'(cycles < 20000), 64'd1);
    rdq.delete();
    chk({tag, "_rd_count"}, 64'(recv_n), 64'(DEPTH));
    chk({tag, "_rd_word0"}, 64'(got[0]), 64'(c.w0));
    chk({tag, "_rd_word4"}, 64'(got[4]), 64'(c.w4));
    chk({tag, "_rd_word1023"}, 64'(got[DEPTH-1]), 64'(c.w_last));
  endtask

  task automatic check_captured(input string tag, input cap_t c);
    @(negedge in_clk);
    @(negedge in_clk);
    chk({tag, "_writes_drained"}, 64'(wq.size()), 64'd0);
    chk({tag, "_done"}, 64'(out_done), 64'd1);
    chk({tag, "_busy"}, 64'(out_busy), 64'd0);
    chk({tag, "_start_addr"}, 64'(out_start_addr), 64'(c.exp_start));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge in_clk);
    while (!out_rd_valid && n < 10) begin
      @(negedge in_clk);
      n++;
    end
    chk(name, 64'(out_rd_valid), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d0;
    wr_t w;
    //            p     trig  base     gaps start w0       w4       w_last
    tbl[0] = '{   4,    10,   'h0000,  1'b0, 6,   'h0006,  'h000A,  'h0405};
    tbl[1] = '{   0,     0,   'h1000,  1'b0, 0,   'h1000,  'h1004,  'h13FF};
    tbl[2] = '{1023,  1030,   'h0000,  1'b0, 7,   'h0007,  'h000B,  'h0406};
    tbl[3] = '{ 100,   500,   'h2000,  1'b1, 400, 'h2190,  'h2194,  'h258F};

    repeat (3) @(posedge in_clk);
    @(negedge in_clk);
    chk("reset_all_outputs", 64'({out_ram_we, out_ram_addr, out_ram_data, out_rd_valid,
        out_rd_data, out_start_addr, out_busy, out_armed, out_done}), 64'd0);
    @(posedge in_clk); #1;
    in_rst = 1'b0;

    // Reset asserted while waiting for a trigger.
    @(posedge in_clk); #1;
    in_arm = 1'b1;
    in_pretrig = ADDR_W'(4);
    @(posedge in_clk); #1;
    in_arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_sample_en = 1'b1;
      in_sample = DATA_W'(16'h0300 + k);
      w.addr = k;
      w.data = 16'h0300 + k;
      w.last = 1'b0;
      wq.push_back(w);
      @(posedge in_clk); #1;
    end
    in_sample_en = 1'b0;
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    chk("armed_in_wait_trig", 64'(out_armed), 64'd1);
    #2 in_rst = 1'b1;
    #1;
    chk("async_reset_outputs", 64'({out_ram_we, out_ram_addr, out_ram_data, out_rd_valid,
        out_rd_data, out_start_addr, out_busy, out_armed, out_done}), 64'd0);
    chk("async_reset_ram_addr", 64'(out_ram_addr), 64'd0);
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 5; k++) begin
      in_sample_en = 1'b1;
      in_trig = 1'b1;
      in_sample = 16'hDEAD;
      @(posedge in_clk); #1;
    end
    in_sample_en = 1'b0;
    in_trig = 1'b0;
    repeat (2) @(posedge in_clk); #1;
    chk("no_write_after_reset", 64'(stray), 64'd0);
    chk("idle_after_reset", 64'({out_busy, out_armed, out_done}), 64'd0);

    // Table-driven captures and full readouts.
    for (int i = 0; i < 4; i++) begin
      capture(tbl[i], -1);
      check_captured($sformatf("cap%0d", i), tbl[i]);
      readout($sformatf("cap%0d", i), tbl[i]);
    end

    // Repeat readout of the last capture with a stalled host, then abort.
    @(posedge in_clk); #1;
    in_rd_ready = 1'b0;
    in_rd_start = 1'b1;
    @(posedge in_clk); #1;
    in_rd_start = 1'b0;
    wait_valid("stall_word0_valid");
    d0 = out_rd_data;
    chk("stall_word0_data", 64'(d0), 64'(tbl[3].w0));
    for (int k = 0; k < 5; k++) begin
      @(negedge in_clk);
      chk("stall_valid_held", 64'(out_rd_valid), 64'd1);
      chk("stall_data_held", 64'(out_rd_data), 64'(d0));
    end
    @(posedge in_clk); #1;
    in_rd_ready = 1'b1;
    @(posedge in_clk); #1;
    in_rd_ready = 1'b0;
    @(negedge in_clk);
    chk("valid_drop_after_accept", 64'(out_rd_valid), 64'd0);
    wait_valid("word1_valid");
    chk("word1_data", 64'(out_rd_data), 64'(shadow[(tbl[3].exp_start + 1) % DEPTH]));
    @(posedge in_clk); #1;
    in_abort = 1'b1;
    @(posedge in_clk); #1;
    in_abort = 1'b0;
    @(negedge in_clk);
    chk("abort_rd_valid", 64'(out_rd_valid), 64'd0);
    chk("abort_rd_idle", 64'({out_busy, out_armed, out_done}), 64'd0);

    // Abort in the middle of the post-trigger phase, then a fresh capture.
    capture(tbl[0], 20);
    @(negedge in_clk);
    @(negedge in_clk);
    chk("mid_post_busy", 64'(out_busy), 64'd1);
    @(posedge in_clk); #1;
    in_abort = 1'b1;
    @(posedge in_clk); #1;
    in_abort = 1'b0;
    @(negedge in_clk);
    chk("abort_post_idle", 64'({out_busy, out_armed, out_done}), 64'd0);
    capture(tbl[1], -1);
    check_captured("recap", tbl[1]);
    readout("recap", tbl[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
